mux_n_to_1_rr: RTL and testbench

Registered N-channel, W-bit multiplexer with per-channel valid/ready handshakes and one output register. It has two selection modes: fixed select and round-robin arbitration. It generalises the team's single-bit 2:1 line mux into a streaming channel selector. It sits between several producer channels and one downstream consumer, and guarantees one transfer per cycle under no backpressure.

---
 rtl/mux_n_to_1_rr.sv | 108 ++++++++++
 tb/tb_mux_n_to_1_rr.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_rr.sv
// Registered N-channel stream selector: fixed-select or round-robin winner,
// one-hot ready back to producers, single output register with same-edge drain/load.

module mux_rr_lane #(
  parameter int W     = 8,
  parameter int SEL_W = 2,
  parameter int K     = 0
) (
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             valid,
  input  logic             gnt,
  input  logic [W-1:0]     data,
  output logic             req,
  output logic [W-1:0]     data_g
);
  // In fixed mode only the addressed lane requests, so an out-of-range select matches nothing
  assign req    = valid && (mode || (sel == SEL_W'(K)));
  assign data_g = gnt ? data : '0;
endmodule

module mux_n_to_1_rr #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [N_CH-1:0]   i_valid,
  input  logic [N_CH*W-1:0] i_data,
  output logic [N_CH-1:0]   o_ready,
  output logic              o_valid,
  output logic [W-1:0]      o_data,
  output logic [SEL_W-1:0]  o_ch,
  input  logic              i_ready
);
  logic [N_CH-1:0]        req;
  logic [N_CH-1:0]        gnt_vec;
  logic [N_CH-1:0][W-1:0] data_g;
  logic [SEL_W-1:0]       ptr;
  logic [SEL_W-1:0]       win;
  logic [SEL_W-1:0]       cand;
  logic [W-1:0]           data_nxt;
  logic                   has_win;
  logic                   space;
  logic                   grant;
  int                     idx;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    mux_rr_lane #(.W(W), .SEL_W(SEL_W), .K(k)) u_lane (
      .mode   (i_mode),
      .sel    (i_sel),
      .valid  (i_valid[k]),
      .gnt    (gnt_vec[k]),
      .data   (i_data[k*W +: W]),
      .req    (req[k]),
      .data_g (data_g[k])
    );
  end

  assign space = !o_valid || i_ready;

  // Rotating scan from ptr; walking offsets downward lets the nearest request win.
  // Fixed mode has at most one request, so the same scan serves both modes.
  always_comb begin
    has_win = 1'b0;
    win     = '0;
    cand    = '0;
    idx     = 0;
    for (int off = N_CH-1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = SEL_W'(idx);
      if (req[cand]) begin
        has_win = 1'b1;
        win     = cand;
      end
    end
  end

  assign grant   = i_en && space && has_win && i_rst_n;
  assign gnt_vec = grant ? (N_CH'(1) << win) : '0;
  assign o_ready = gnt_vec;

  always_comb begin
    data_nxt = '0;
    for (int k = 0; k < N_CH; k++) data_nxt = data_nxt | data_g[k];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      ptr     <= '0;
    end else if (grant) begin
      o_valid <= 1'b1;
      o_data  <= data_nxt;
      o_ch    <= win;
      ptr     <= (win == SEL_W'(N_CH-1)) ? '0 : win + 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// Bench for mux_n_to_1_rr: directed vector table, corner sequences, random vs reference model.

module tb_mux_n_to_1_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en, mode, rdy;
  logic [1:0]     sel;
  logic [N-1:0]   valid;
  logic [N*W-1:0] data;
  logic [N-1:0]   ready;
  logic           ovld;
  logic [W-1:0]   odata;
  logic [1:0]     och;

  logic           en3, mode3, rdy3;
  logic [1:0]     sel3;
  logic [2:0]     valid3;
  logic [23:0]    data3;
  logic [2:0]     ready3;
  logic           ovld3;
  logic [7:0]     odata3;
  logic [1:0]     och3;

  always #5 clk = ~clk;

  mux_n_to_1_rr #(.N_CH(N), .W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sel(sel),
    .i_valid(valid), .i_data(data), .o_ready(ready), .o_valid(ovld),
    .o_data(odata), .o_ch(och), .i_ready(rdy)
  );

  mux_n_to_1_rr #(.N_CH(3), .W(8)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en3), .i_mode(mode3), .i_sel(sel3),
    .i_valid(valid3), .i_data(data3), .o_ready(ready3), .o_valid(ovld3),
    .o_data(odata3), .o_ch(och3), .i_ready(rdy3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic en, mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic rdy;
    logic [3:0] e_ready;
    logic e_valid;
    logic [1:0] e_ch;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[21];

  // Reference model: output register contents and the next channel to favour
  logic       m_v;
  logic [7:0] m_d;
  int         m_ch;
  int         m_ptr;

  function automatic int ref_winner(input logic md, input int s, input logic [3:0] v);
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int off = 0; off < N; off++)
      if (v[(m_ptr + off) % N]) return (m_ptr + off) % N;
    return -1;
  endfunction

  initial begin
    tbl[0]  = '{1,0,2,4'hF,1, 4'h4,1,2,8'h12};
    tbl[1]  = '{1,0,2,4'hF,1, 4'h4,1,2,8'h12};
    tbl[2]  = '{1,1,0,4'hF,1, 4'h8,1,3,8'h13};
    tbl[3]  = '{1,1,0,4'hF,1, 4'h1,1,0,8'h10};
    tbl[4]  = '{1,1,0,4'hF,1, 4'h2,1,1,8'h11};
    tbl[5]  = '{1,1,0,4'hF,1, 4'h4,1,2,8'h12};
    tbl[6]  = '{1,1,0,4'hF,1, 4'h8,1,3,8'h13};
    tbl[7]  = '{1,1,0,4'hA,1, 4'h2,1,1,8'h11};
    tbl[8]  = '{1,1,0,4'hA,1, 4'h8,1,3,8'h13};
    tbl[9]  = '{1,1,0,4'hA,1, 4'h2,1,1,8'h11};
    tbl[10] = '{1,1,0,4'hA,1, 4'h8,1,3,8'h13};
    tbl[11] = '{1,1,0,4'hF,0, 4'h0,1,3,8'h13};
    tbl[12] = '{1,1,0,4'hF,0, 4'h0,1,3,8'h13};
    tbl[13] = '{1,1,0,4'hF,0, 4'h0,1,3,8'h13};
    tbl[14] = '{1,1,0,4'hF,1, 4'h1,1,0,8'h10};
    tbl[15] = '{0,1,0,4'hF,1, 4'h0,0,0,8'h10};
    tbl[16] = '{0,1,0,4'hF,1, 4'h0,0,0,8'h10};
    tbl[17] = '{1,1,0,4'hF,1, 4'h2,1,1,8'h11};
    tbl[18] = '{1,0,1,4'hD,1, 4'h0,0,1,8'h11};
    tbl[19] = '{1,0,0,4'h1,1, 4'h1,1,0,8'h10};
    tbl[20] = '{1,1,0,4'hF,0, 4'h0,1,0,8'h10};

    // Reset with every input active
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 2'd0; valid = 4'hF; rdy = 1'b1;
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    en3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; valid3 = 3'b000; rdy3 = 1'b1;
    data3 = {8'h22, 8'h21, 8'h20};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_valid", ovld, 0);
    chk("rst_data", odata, 0);
    chk("rst_ch", och, 0);
    en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    foreach (tbl[i]) begin
      en = tbl[i].en; mode = tbl[i].mode; sel = tbl[i].sel;
      valid = tbl[i].valid; rdy = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].e_ready);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), ovld, tbl[i].e_valid);
      chk($sformatf("tbl%0d_ch", i), och, tbl[i].e_ch);
      chk($sformatf("tbl%0d_data", i), odata, tbl[i].e_data);
    end

    // Three-channel instance: select index 3 never grants, index 2 does
    en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111;
    @(negedge clk);
    chk("oor_ready", ready3, 0);
    @(posedge clk); #1;
    chk("oor_valid", ovld3, 0);
    sel3 = 2'd2;
    @(negedge clk);
    chk("n3_ready", ready3, 3'b100);
    @(posedge clk); #1;
    chk("n3_valid", ovld3, 1);
    chk("n3_ch", och3, 2);
    chk("n3_data", odata3, 8'h22);
    en3 = 1'b0;

    // Asynchronous reset while a word is held
    en = 1'b1; mode = 1'b1; valid = 4'hF; rdy = 1'b1;
    @(posedge clk); #1;
    chk("pre_arst_valid", ovld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ovld, 0);
    chk("arst_ready", ready, 0);
    chk("arst_ch", och, 0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomised traffic against the reference model (state is fresh from reset)
    m_v = 1'b0; m_d = 8'h00; m_ch = 0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      int w;
      logic g;
      logic [N-1:0] er;
      en    = ($urandom_range(0, 9) < 8);
      mode  = $urandom_range(0, 1) == 1;
      sel   = 2'($urandom_range(0, 3));
      valid = 4'($urandom_range(0, 15));
      rdy   = ($urandom_range(0, 9) < 7);
      data  = {$urandom()};
      w  = ref_winner(mode, int'(sel), valid);
      g  = en && (!m_v || rdy) && (w >= 0);
      er = '0;
      if (g) er[w] = 1'b1;
      @(negedge clk);
      chk("rnd_ready", ready, er);
      if (g) begin
        m_v = 1'b1;
        m_d = data[w*W +: W];
        m_ch = w;
        m_ptr = (w + 1) % N;
      end else if (m_v && rdy) begin
        m_v = 1'b0;
      end
      @(posedge clk); #1;
      chk("rnd_valid", ovld, m_v);
      chk("rnd_ch", och, m_ch);
      chk("rnd_data", odata, m_d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
